dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory of the pipelined processor between two requesters: the CPU MEM stage and a debug reader that scans memory for LED display.
- Sits between the MEM stage / debug scanner and the data-memory instance.
- Issues at most one memory access per cycle. The CPU has priority; a starvation counter guarantees the debug reader progress.
- Also drives the registered write-observation outputs write_data_out / dm_write_enable_out.

---
 rtl/dmem_port_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the debug
// reader: the CPU has priority, and a starvation counter force-grants debug.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] write_data_out,
  output logic              dm_write_enable_out
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_DBG} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_starve_cnt;
  logic [DATA_W-1:0] r_cpu_hold, r_dbg_hold, r_wdata_obs;
  logic              r_we_obs;
  logic              w_force_dbg, w_cpu_gnt, w_dbg_gnt;

  // Grants are masked while reset is held so every output reads 0 at once.
  always_comb begin
    w_force_dbg = dbg_req && (r_starve_cnt == LP_MAX_WAIT);
    w_dbg_gnt   = !reset && (w_force_dbg || (!cpu_req && dbg_req));
    w_cpu_gnt   = !reset && cpu_req && !w_force_dbg;
    cpu_stall   = !reset && cpu_req && !w_cpu_gnt;
    dbg_gnt     = w_dbg_gnt;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_gnt) begin
      mem_en   = 1'b1;
      mem_addr = dbg_addr;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_cpu_gnt && !cpu_we) w_state_nxt = RD_CPU;
    else if (w_dbg_gnt)       w_state_nxt = RD_DBG;
  end

  always_comb begin
    cpu_rvalid = (r_state == RD_CPU);
    dbg_rvalid = (r_state == RD_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_hold;
    dbg_rdata  = dbg_rvalid ? mem_rdata : r_dbg_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_cpu_hold   <= '0;
      r_dbg_hold   <= '0;
      r_wdata_obs  <= '0;
      r_we_obs     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!dbg_req || w_dbg_gnt)            r_starve_cnt <= '0;
      else if (r_starve_cnt != LP_MAX_WAIT) r_starve_cnt <= r_starve_cnt + 4'd1;
      if (r_state == RD_CPU) r_cpu_hold <= mem_rdata;
      if (r_state == RD_DBG) r_dbg_hold <= mem_rdata;
      r_we_obs <= w_cpu_gnt && cpu_we;
      if (w_cpu_gnt && cpu_we) r_wdata_obs <= cpu_wdata;
    end
  end

  assign write_data_out      = r_wdata_obs;
  assign dm_write_enable_out = r_we_obs;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed vector bench for dmem_port_arbiter with a behavioural 64x64 memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req;
  logic [5:0]  cpu_addr, dbg_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [63:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we, dm_write_enable_out;
  logic [5:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata, write_data_out;
  logic [63:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(6), .DATA_W(64), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .write_data_out(write_data_out), .dm_write_enable_out(dm_write_enable_out)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic        stall, gnt, en, we;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic        crv;
    logic [63:0] crd;
    logic        drv;
    logic [63:0] drd;
    logic        wen;
    logic [63:0] wdo;
  } out_t;

  typedef struct {
    logic        creq, cwe;
    logic [5:0]  caddr;
    logic [63:0] cwd;
    logic        dreq;
    logic [5:0]  daddr;
    out_t        e;
  } vec_t;

  localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;

  function automatic out_t o(logic stall, logic gnt, logic en, logic we, logic [5:0] addr,
                             logic [63:0] wdata, logic crv, logic [63:0] crd, logic drv,
                             logic [63:0] drd, logic wen, logic [63:0] wdo);
    o = '{stall, gnt, en, we, addr, wdata, crv, crd, drv, drd, wen, wdo};
  endfunction

  function automatic vec_t mk(logic creq, logic cwe, logic [5:0] caddr, logic [63:0] cwd,
                              logic dreq, logic [5:0] daddr, out_t e);
    mk = '{creq, cwe, caddr, cwd, dreq, daddr, e};
  endfunction

  function automatic out_t sample();
    sample = '{cpu_stall, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid,
               cpu_rdata, dbg_rvalid, dbg_rdata, dm_write_enable_out, write_data_out};
  endfunction

  task automatic chk(input string nm, input out_t exp);
    out_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %p want %p", nm, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [5:0] caddr,
                       input logic [63:0] cwd, input logic dreq, input logic [5:0] daddr);
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_addr = daddr;
    #1;
  endtask

  task automatic chk_arb(input string nm, input logic e_dbg, input logic e_en,
                         input logic [5:0] e_addr, input logic e_crv, input logic e_drv);
    logic [9:0] act, exp;
    act = {cpu_stall, dbg_gnt, mem_en, mem_addr, cpu_rvalid};
    exp = {e_dbg, e_dbg, e_en, e_addr, e_crv};
    n_vec++;
    if (act !== exp || dbg_rvalid !== e_drv) begin
      n_err++;
      $display("FAIL %s: got stall/gnt/en/addr/crv=%b drv=%b want %b drv=%b",
               nm, act, dbg_rvalid, exp, e_drv);
    end
  endtask

  vec_t vt[17];
  out_t z;

  initial begin
    z = '0;
    vt[0]  = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,0,    0,0,     0,0));
    vt[1]  = mk(1,0,5,0,     0,0, o(0,0,1,0,5,0,     0,0,    0,0,     0,0));
    vt[2]  = mk(1,0,6,0,     0,0, o(0,0,1,0,6,0,     1,'h11, 0,0,     0,0));
    vt[3]  = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     1,'h22, 0,0,     0,0));
    vt[4]  = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,'h22, 0,0,     0,0));
    vt[5]  = mk(0,0,0,0,     1,3, o(0,1,1,0,3,0,     0,'h22, 0,0,     0,0));
    vt[6]  = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,'h22, 1,'h33,  0,0));
    vt[7]  = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,'h22, 0,'h33,  0,0));
    vt[8]  = mk(1,1,5,D,     0,0, o(0,0,1,1,5,D,     0,'h22, 0,'h33,  0,0));
    vt[9]  = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,'h22, 0,'h33,  1,D));
    vt[10] = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,'h22, 0,'h33,  0,D));
    vt[11] = mk(1,1,7,'h77,  0,0, o(0,0,1,1,7,'h77,  0,'h22, 0,'h33,  0,D));
    vt[12] = mk(0,0,0,0,     1,7, o(0,1,1,0,7,0,     0,'h22, 0,'h33,  1,'h77));
    vt[13] = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,'h22, 1,'h77,  0,'h77));
    vt[14] = mk(1,0,5,0,     0,0, o(0,0,1,0,5,0,     0,'h22, 0,'h77,  0,'h77));
    vt[15] = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     1,D,    0,'h77,  0,'h77));
    vt[16] = mk(0,0,0,0,     0,0, o(0,0,0,0,0,0,     0,D,    0,'h77,  0,'h77));

    for (int i = 0; i < 64; i++) mem[i] <= '0;
    mem[3] <= 64'h33;
    mem[5] <= 64'h11;
    mem[6] <= 64'h22;
    mem_rdata = '0;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dbg_req = 0; dbg_addr = 0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", z);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwd, vt[i].dreq, vt[i].daddr);
      chk($sformatf("vec%0d", i), vt[i].e);
    end

    // Continuous contention: CPU 4 cycles, then debug once, repeating.
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 6, 0, 1, 3);
      chk_arb($sformatf("starve%0d", k), (k % 5) == 4, 1, ((k % 5) == 4) ? 6'd3 : 6'd6,
              k > 0 && ((k - 1) % 5) != 4, k > 0 && ((k - 1) % 5) == 4);
    end

    // Debug withdrawn while denied: counter clears, next force needs 4 more denials.
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 6, 0, 1, 3);
      chk_arb($sformatf("wd_pre%0d", k), 0, 1, 6, k > 0, k == 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk_arb("wd_gap", 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 6, 0, 1, 3);
      chk_arb($sformatf("wd_post%0d", k), k == 4, 1, (k == 4) ? 6'd3 : 6'd6, k > 0, 0);
    end

    // Reset with a CPU read return pending.
    drive(1, 0, 5, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_midcycle", z);
    @(negedge clk) cpu_req = 0;
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("post_reset%0d", k), z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
